// File: rtl/instrmem_pkg.sv
// Shared types and defaults for the switch-driven instruction memory loader.
package instrmem_pkg;

  typedef enum logic {
    StLoad = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [31:0] Nop = 32'h0000_0000;

  localparam int unsigned DefDepthLog2      = 6;
  localparam int unsigned DefDebounceCycles = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-level debouncer and rising-edge pulse for one push button.
module btn_debounce
  import instrmem_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  // The counter runs only while the synchronized input disagrees with the accepted level;
  // the level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
        pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/instrmem_loader.sv
// Instruction memory filled byte-by-byte from board switches, then released to the CPU.
module instrmem_loader
  import instrmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2      = DefDepthLog2,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic                  clk50M,
  input  logic                  rst,
  input  logic [31:0]           instrmem_addr,
  output logic [31:0]           instrmem_data,
  input  logic [7:0]            sw_byte,
  input  logic                  btn_strobe,
  input  logic                  btn_run,
  output logic                  cpu_run,
  output logic [DEPTH_LOG2:0]   load_count
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  state_e              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         asm_q, asm_d;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic                wr_en;
  logic                full;
  logic                strobe_pulse;
  logic                run_pulse;
  logic [31:0]         mem_q [Words];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_strobe_db (
    .clk_i  (clk50M),
    .rst_ni (rst),
    .btn_i  (btn_strobe),
    .pulse_o(strobe_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk_i  (clk50M),
    .rst_ni (rst),
    .btn_i  (btn_run),
    .pulse_o(run_pulse)
  );

  // wr_ptr never exceeds Words, so its MSB alone marks a full memory.
  assign full = wr_ptr_q[DEPTH_LOG2];

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    wr_ptr_d   = wr_ptr_q;
    wr_en      = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (run_pulse) begin
          state_d    = StRun;
          byte_idx_d = '0;
        end else if (strobe_pulse && !full) begin
          unique case (byte_idx_q)
            2'd0: asm_d[7:0]   = sw_byte;
            2'd1: asm_d[15:8]  = sw_byte;
            2'd2: asm_d[23:16] = sw_byte;
            2'd3: begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
            default: ;
          endcase
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end
      StRun: begin
        if (run_pulse) begin
          state_d    = StLoad;
          wr_ptr_d   = '0;
          byte_idx_d = '0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      state_q    <= StLoad;
      byte_idx_q <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // No reset: anything at or above wr_ptr is masked on the read side.
  always_ff @(posedge clk50M) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {sw_byte, asm_q};
    end
  end

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  addr_hi_zero;
  logic                  rd_hit;
  logic                  unused_addr_lsb;

  assign rd_idx          = instrmem_addr[DEPTH_LOG2+1:2];
  assign addr_hi_zero    = (instrmem_addr[31:DEPTH_LOG2+2] == '0);
  assign rd_hit          = cpu_run && addr_hi_zero && ({1'b0, rd_idx} < wr_ptr_q);
  assign unused_addr_lsb = ^instrmem_addr[1:0];

  assign instrmem_data = rd_hit ? mem_q[rd_idx] : Nop;
  assign cpu_run       = (state_q == StRun);
  assign load_count    = wr_ptr_q;

endmodule

// File: tb/tb_instrmem_loader.sv
// Directed bench for instrmem_loader with a short debounce window.
module tb_instrmem_loader;

  localparam int unsigned DepthLog2 = 6;
  localparam int unsigned Debounce  = 4;

  logic              clk50M;
  logic              rst;
  logic [31:0]       instrmem_addr;
  logic [31:0]       instrmem_data;
  logic [7:0]        sw_byte;
  logic              btn_strobe;
  logic              btn_run;
  logic              cpu_run;
  logic [DepthLog2:0] load_count;

  int vectors;
  int miscompares;

  instrmem_loader #(
    .DEPTH_LOG2     (DepthLog2),
    .DEBOUNCE_CYCLES(Debounce)
  ) dut (
    .clk50M       (clk50M),
    .rst          (rst),
    .instrmem_addr(instrmem_addr),
    .instrmem_data(instrmem_data),
    .sw_byte      (sw_byte),
    .btn_strobe   (btn_strobe),
    .btn_run      (btn_run),
    .cpu_run      (cpu_run),
    .load_count   (load_count)
  );

  initial clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required finish before 5ms");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: hold a button long enough to pass the debouncer, then release it.
  task automatic press(input logic s, input logic r, input logic [7:0] b);
    @(posedge clk50M); #1;
    sw_byte    = b;
    btn_strobe = s;
    btn_run    = r;
    repeat (8) @(posedge clk50M);
    #1;
    btn_strobe = 1'b0;
    btn_run    = 1'b0;
    repeat (8) @(posedge clk50M);
    @(negedge clk50M);
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) press(1'b1, 1'b0, w[8*k +: 8]);
  endtask

  task automatic do_reset;
    @(negedge clk50M);
    rst = 1'b0;
    repeat (3) @(negedge clk50M);
    rst = 1'b1;
    @(negedge clk50M);
  endtask

  task automatic test_reset;
    logic [31:0] addrs [3];
    addrs[0] = 32'h0;
    addrs[1] = 32'h4;
    addrs[2] = 32'h100;
    do_reset();
    vectors++;
    if (cpu_run !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cpu_run: got %b want 0", cpu_run);
    end
    vectors++;
    if (load_count !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_load_count: got %0d want 0", load_count);
    end
    for (int i = 0; i < 3; i++) begin
      instrmem_addr = addrs[i];
      #1;
      vectors++;
      if (instrmem_data !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_data addr=%h: got %h want 0", addrs[i], instrmem_data);
      end
    end
  endtask

  task automatic test_basic_load;
    load_word(32'h2421_0001);
    press(1'b0, 1'b1, 8'h00);
    vectors++;
    if (load_count !== 7'd1 || cpu_run !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_state: got count=%0d run=%b want count=1 run=1", load_count, cpu_run);
    end
    instrmem_addr = 32'h0; #1;
    vectors++;
    if (instrmem_data !== 32'h2421_0001) begin
      miscompares++;
      $display("FAIL basic_addr0: got %h want 24210001", instrmem_data);
    end
    instrmem_addr = 32'h4; #1;
    vectors++;
    if (instrmem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL basic_addr4: got %h want 00000000", instrmem_data);
    end
    instrmem_addr = 32'h3; #1;
    vectors++;
    if (instrmem_data !== 32'h2421_0001) begin
      miscompares++;
      $display("FAIL basic_addr3: got %h want 24210001", instrmem_data);
    end
    press(1'b0, 1'b1, 8'h00);
    vectors++;
    if (cpu_run !== 1'b0 || load_count !== 7'd0) begin
      miscompares++;
      $display("FAIL basic_back_to_load: got run=%b count=%0d want 0 0", cpu_run, load_count);
    end
  endtask

  task automatic test_short_press;
    @(posedge clk50M); #1;
    sw_byte    = 8'h55;
    btn_strobe = 1'b1;
    repeat (3) @(posedge clk50M);
    #1;
    btn_strobe = 1'b0;
    repeat (8) @(posedge clk50M);
    load_word(32'hDDCC_BBAA);
    vectors++;
    if (load_count !== 7'd1) begin
      miscompares++;
      $display("FAIL short_count: got %0d want 1", load_count);
    end
    press(1'b0, 1'b1, 8'h00);
    instrmem_addr = 32'h0; #1;
    vectors++;
    if (instrmem_data !== 32'hDDCC_BBAA) begin
      miscompares++;
      $display("FAIL short_word: got %h want ddccbbaa", instrmem_data);
    end
    press(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_full;
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      load_word(w);
    end
    vectors++;
    if (load_count !== 7'd64) begin
      miscompares++;
      $display("FAIL full_count: got %0d want 64", load_count);
    end
    load_word(32'h1111_1111);
    vectors++;
    if (load_count !== 7'd64) begin
      miscompares++;
      $display("FAIL full_count_after_extra: got %0d want 64", load_count);
    end
    press(1'b0, 1'b1, 8'h00);
    instrmem_addr = 32'hFC; #1;
    vectors++;
    if (instrmem_data !== 32'hFFFE_FDFC) begin
      miscompares++;
      $display("FAIL full_mem63: got %h want fffefdfc", instrmem_data);
    end
    instrmem_addr = 32'h0; #1;
    vectors++;
    if (instrmem_data !== 32'h0302_0100) begin
      miscompares++;
      $display("FAIL full_mem0: got %h want 03020100", instrmem_data);
    end
    instrmem_addr = 32'h80; #1;
    vectors++;
    if (instrmem_data !== 32'h8382_8180) begin
      miscompares++;
      $display("FAIL full_mem32: got %h want 83828180", instrmem_data);
    end
    instrmem_addr = 32'h100; #1;
    vectors++;
    if (instrmem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL full_addr100: got %h want 00000000", instrmem_data);
    end
    press(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_partial;
    load_word(32'h4433_2211);
    press(1'b1, 1'b0, 8'h55);
    press(1'b1, 1'b0, 8'h66);
    press(1'b0, 1'b1, 8'h00);
    vectors++;
    if (load_count !== 7'd1 || cpu_run !== 1'b1) begin
      miscompares++;
      $display("FAIL partial_state: got count=%0d run=%b want 1 1", load_count, cpu_run);
    end
    instrmem_addr = 32'h0; #1;
    vectors++;
    if (instrmem_data !== 32'h4433_2211) begin
      miscompares++;
      $display("FAIL partial_addr0: got %h want 44332211", instrmem_data);
    end
    instrmem_addr = 32'h4; #1;
    vectors++;
    if (instrmem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL partial_addr4: got %h want 00000000", instrmem_data);
    end
    press(1'b0, 1'b1, 8'h00);
    vectors++;
    if (cpu_run !== 1'b0 || load_count !== 7'd0) begin
      miscompares++;
      $display("FAIL partial_second_run: got run=%b count=%0d want 0 0", cpu_run, load_count);
    end
  endtask

  task automatic test_back_to_back;
    press(1'b1, 1'b0, 8'h01);
    press(1'b1, 1'b0, 8'h02);
    press(1'b1, 1'b0, 8'h03);
    press(1'b1, 1'b1, 8'h04);
    vectors++;
    if (cpu_run !== 1'b1 || load_count !== 7'd0) begin
      miscompares++;
      $display("FAIL both_state: got run=%b count=%0d want 1 0", cpu_run, load_count);
    end
    instrmem_addr = 32'h0; #1;
    vectors++;
    if (instrmem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL both_addr0: got %h want 00000000", instrmem_data);
    end
    press(1'b0, 1'b1, 8'h00);
    load_word(32'hA1B2_C3D4);
    press(1'b0, 1'b1, 8'h00);
    instrmem_addr = 32'h0; #1;
    vectors++;
    if (instrmem_data !== 32'hA1B2_C3D4 || load_count !== 7'd1) begin
      miscompares++;
      $display("FAIL both_reload: got %h count=%0d want a1b2c3d4 1", instrmem_data, load_count);
    end
  endtask

  task automatic test_reset_midload;
    // In RUN with a visible word: reset must clear outputs before any clock edge.
    @(negedge clk50M);
    #2 rst = 1'b0;
    #2;
    vectors++;
    if (cpu_run !== 1'b0 || load_count !== 7'd0 || instrmem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset_run: got run=%b count=%0d data=%h want 0 0 0",
               cpu_run, load_count, instrmem_data);
    end
    @(negedge clk50M);
    rst = 1'b1;
    load_word(32'h0BAD_F00D);
    press(1'b1, 1'b0, 8'hEE);
    press(1'b1, 1'b0, 8'hEF);
    @(negedge clk50M);
    #2 rst = 1'b0;
    #2;
    vectors++;
    if (cpu_run !== 1'b0 || load_count !== 7'd0 || instrmem_data !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset_load: got run=%b count=%0d data=%h want 0 0 0",
               cpu_run, load_count, instrmem_data);
    end
    @(negedge clk50M);
    rst = 1'b1;
    load_word(32'h1234_5678);
    press(1'b0, 1'b1, 8'h00);
    instrmem_addr = 32'h0; #1;
    vectors++;
    if (instrmem_data !== 32'h1234_5678 || load_count !== 7'd1) begin
      miscompares++;
      $display("FAIL post_reset_load: got %h count=%0d want 12345678 1",
               instrmem_data, load_count);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b0;
    instrmem_addr = 32'h0;
    sw_byte       = 8'h00;
    btn_strobe    = 1'b0;
    btn_run       = 1'b0;
    test_reset();
    test_basic_load();
    test_short_press();
    test_full();
    test_partial();
    test_back_to_back();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
